// File: rtl/line_window_buffer_pkg.sv
// -----------------------------------------------------------------------------
// line_window_buffer_pkg
// Shared dimensions and helpers for the streaming line window buffer and the
// older addressed frame_buffer users.
//   DEF_*        default frame geometry (640 columns, 4 ring rows, 3-line
//                window, 24-bit pixels)
//   width_of     index width for a range of v values (minimum 1 bit)
//   ring_add     (a + b) mod m for operands already known to be below m
//                (b may equal m), which avoids a real divider
// -----------------------------------------------------------------------------
package line_window_buffer_pkg;

  localparam int DEF_COLUMNS     = 640;
  localparam int DEF_ROWS        = 4;
  localparam int DEF_WINDOW      = 3;
  localparam int DEF_PIXEL_DEPTH = 24;

  function automatic int width_of(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic int ring_add(input int a, input int b, input int m);
    int s;
    s = a + b;
    return (s >= m) ? s - m : s;
  endfunction

  localparam int DEF_COL_W = width_of(DEF_COLUMNS);
  localparam int DEF_ROW_W = width_of(DEF_ROWS);
  localparam int DEF_CNT_W = width_of(DEF_ROWS + 1);

endpackage

// File: rtl/line_window_buffer_if.sv
// -----------------------------------------------------------------------------
// line_window_buffer_if
// Pixel-in / window-out handshake bundle of the line window buffer.
//   I_PIXEL, I_PIXEL_VALID, O_PIXEL_READY    raster pixel input stream
//   O_WINDOW, O_WINDOW_COL, O_WINDOW_VALID,
//   I_WINDOW_READY                           vertical window output stream
//   O_ROWS_STORED                            completed, unretired lines
// The slave modport is the buffer side; master is the producer/consumer side.
// -----------------------------------------------------------------------------
interface line_window_buffer_if
  import line_window_buffer_pkg::*;
#(
  parameter int P_COLUMNS     = DEF_COLUMNS,
  parameter int P_ROWS        = DEF_ROWS,
  parameter int P_WINDOW      = DEF_WINDOW,
  parameter int P_PIXEL_DEPTH = DEF_PIXEL_DEPTH
) ();

  localparam int COL_W = width_of(P_COLUMNS);
  localparam int CNT_W = width_of(P_ROWS + 1);

  logic [P_PIXEL_DEPTH-1:0]          I_PIXEL;
  logic                              I_PIXEL_VALID;
  logic                              O_PIXEL_READY;
  logic [P_WINDOW*P_PIXEL_DEPTH-1:0] O_WINDOW;
  logic [COL_W-1:0]                  O_WINDOW_COL;
  logic                              O_WINDOW_VALID;
  logic                              I_WINDOW_READY;
  logic [CNT_W-1:0]                  O_ROWS_STORED;

  modport slave (
    input  I_PIXEL, I_PIXEL_VALID, I_WINDOW_READY,
    output O_PIXEL_READY, O_WINDOW, O_WINDOW_COL, O_WINDOW_VALID, O_ROWS_STORED
  );

  modport master (
    output I_PIXEL, I_PIXEL_VALID, I_WINDOW_READY,
    input  O_PIXEL_READY, O_WINDOW, O_WINDOW_COL, O_WINDOW_VALID, O_ROWS_STORED
  );

endinterface

// File: rtl/line_window_buffer_ring_row_store.sv
// -----------------------------------------------------------------------------
// line_window_buffer_ring_row_store
// P_ROWS x P_COLUMNS pixel storage (the ring_row_store of the window buffer).
//   clk                 clock (storage has no reset on purpose)
//   wr_en/wr_row/wr_col/wr_data   single synchronous write port
//   rd_rows/rd_col/rd_data        P_WINDOW combinational read ports sharing
//                                 one column, each with its own ring row
// -----------------------------------------------------------------------------
module line_window_buffer_ring_row_store
  import line_window_buffer_pkg::*;
#(
  parameter  int P_COLUMNS     = DEF_COLUMNS,
  parameter  int P_ROWS        = DEF_ROWS,
  parameter  int P_WINDOW      = DEF_WINDOW,
  parameter  int P_PIXEL_DEPTH = DEF_PIXEL_DEPTH,
  localparam int COL_W         = width_of(P_COLUMNS),
  localparam int ROW_W         = width_of(P_ROWS)
) (
  input  logic                                     clk,
  input  logic                                     wr_en,
  input  logic [ROW_W-1:0]                         wr_row,
  input  logic [COL_W-1:0]                         wr_col,
  input  logic [P_PIXEL_DEPTH-1:0]                 wr_data,
  input  logic [P_WINDOW-1:0][ROW_W-1:0]           rd_rows,
  input  logic [COL_W-1:0]                         rd_col,
  output logic [P_WINDOW-1:0][P_PIXEL_DEPTH-1:0]   rd_data
);

  logic [P_PIXEL_DEPTH-1:0] mem [P_ROWS][P_COLUMNS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_row][wr_col] <= wr_data;
    end
  end

  // The writer only ever targets the line after the stored ones, so these
  // reads never see a same-cycle write to the same address.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < P_WINDOW; k++) begin
      rd_data[k] = mem[rd_rows[k]][rd_col];
    end
  end

endmodule

// File: rtl/line_window_buffer.sv
// -----------------------------------------------------------------------------
// line_window_buffer
// Streaming circular line buffer: stores raster lines in a ring of P_ROWS
// lines and emits P_WINDOW-tall vertical windows, one column per cycle.
//   I_CLK     clock
//   I_RESET   asynchronous active-high reset (pointers, counters, outputs)
//   I_FLUSH   synchronous clear of pointers and window valid (frame start)
//   bus       line_window_buffer_if.slave: pixel input and window output
//             handshakes plus the stored-line count
// P_ROWS must be larger than P_WINDOW so the line being written never
// overlaps the lines being read.
// -----------------------------------------------------------------------------
module line_window_buffer
  import line_window_buffer_pkg::*;
#(
  parameter int P_COLUMNS     = DEF_COLUMNS,
  parameter int P_ROWS        = DEF_ROWS,
  parameter int P_WINDOW      = DEF_WINDOW,
  parameter int P_PIXEL_DEPTH = DEF_PIXEL_DEPTH
) (
  input  logic                 I_CLK,
  input  logic                 I_RESET,
  input  logic                 I_FLUSH,
  line_window_buffer_if.slave  bus
);

  localparam int COL_W = width_of(P_COLUMNS);
  localparam int ROW_W = width_of(P_ROWS);
  localparam int CNT_W = width_of(P_ROWS + 1);
  localparam int WIN_W = P_WINDOW * P_PIXEL_DEPTH;

  logic [COL_W-1:0] wr_col_q, wr_col_d;
  logic [COL_W-1:0] rd_col_q, rd_col_d;
  logic [ROW_W-1:0] rd_row_q, rd_row_d;
  logic [CNT_W-1:0] stored_q, stored_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [COL_W-1:0] win_col_q, win_col_d;
  logic             win_valid_q, win_valid_d;

  logic                                   pix_ready;
  logic                                   accept;
  logic                                   avail;
  logic                                   load;
  logic                                   row_done;
  logic                                   retire;
  logic [ROW_W-1:0]                       wr_row;
  logic [P_WINDOW-1:0][ROW_W-1:0]         rd_rows;
  logic [P_WINDOW-1:0][P_PIXEL_DEPTH-1:0] rd_data;

  // Handshake decisions and ring addressing. Flush suppresses both the
  // write and the window load so the cleared state is exact on the next edge.
  always_comb begin
    pix_ready = (stored_q < CNT_W'(P_ROWS));
    accept    = bus.I_PIXEL_VALID && pix_ready && !I_FLUSH;
    avail     = (stored_q >= CNT_W'(P_WINDOW));
    load      = avail && (!win_valid_q || bus.I_WINDOW_READY) && !I_FLUSH;
    row_done  = accept && (wr_col_q == COL_W'(P_COLUMNS - 1));
    retire    = load && (rd_col_q == COL_W'(P_COLUMNS - 1));
    wr_row    = ROW_W'(ring_add(int'(rd_row_q), int'(stored_q), P_ROWS));
    rd_rows   = '0;
    for (int k = 0; k < P_WINDOW; k++) begin
      rd_rows[k] = ROW_W'(ring_add(int'(rd_row_q), k, P_ROWS));
    end
  end

  always_comb begin
    wr_col_d    = wr_col_q;
    rd_col_d    = rd_col_q;
    rd_row_d    = rd_row_q;
    stored_d    = stored_q;
    win_d       = win_q;
    win_col_d   = win_col_q;
    win_valid_d = win_valid_q;

    if (I_FLUSH) begin
      wr_col_d    = '0;
      rd_col_d    = '0;
      rd_row_d    = '0;
      stored_d    = '0;
      win_valid_d = 1'b0;
    end else begin
      if (accept) begin
        wr_col_d = row_done ? '0 : wr_col_q + COL_W'(1);
      end

      if (load) begin
        win_d       = rd_data;
        win_col_d   = rd_col_q;
        win_valid_d = 1'b1;
        rd_col_d    = retire ? '0 : rd_col_q + COL_W'(1);
        if (retire) begin
          rd_row_d = (rd_row_q == ROW_W'(P_ROWS - 1)) ? '0 : rd_row_q + ROW_W'(1);
        end
      end else if (win_valid_q && bus.I_WINDOW_READY) begin
        win_valid_d = 1'b0;
      end

      // A line completing and a line retiring on the same edge cancel out.
      if (row_done && !retire) begin
        stored_d = stored_q + CNT_W'(1);
      end else if (retire && !row_done) begin
        stored_d = stored_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      wr_col_q    <= '0;
      rd_col_q    <= '0;
      rd_row_q    <= '0;
      stored_q    <= '0;
      win_q       <= '0;
      win_col_q   <= '0;
      win_valid_q <= 1'b0;
    end else begin
      wr_col_q    <= wr_col_d;
      rd_col_q    <= rd_col_d;
      rd_row_q    <= rd_row_d;
      stored_q    <= stored_d;
      win_q       <= win_d;
      win_col_q   <= win_col_d;
      win_valid_q <= win_valid_d;
    end
  end

  line_window_buffer_ring_row_store #(
    .P_COLUMNS     (P_COLUMNS),
    .P_ROWS        (P_ROWS),
    .P_WINDOW      (P_WINDOW),
    .P_PIXEL_DEPTH (P_PIXEL_DEPTH)
  ) u_store (
    .clk     (I_CLK),
    .wr_en   (accept),
    .wr_row  (wr_row),
    .wr_col  (wr_col_q),
    .wr_data (bus.I_PIXEL),
    .rd_rows (rd_rows),
    .rd_col  (rd_col_q),
    .rd_data (rd_data)
  );

  assign bus.O_PIXEL_READY  = pix_ready;
  assign bus.O_WINDOW       = win_q;
  assign bus.O_WINDOW_COL   = win_col_q;
  assign bus.O_WINDOW_VALID = win_valid_q;
  assign bus.O_ROWS_STORED  = stored_q;

endmodule

// File: tb/tb_line_window_buffer.sv
// -----------------------------------------------------------------------------
// tb_line_window_buffer
// Bench for line_window_buffer with a 4-column, 4-row ring and 3-line windows.
// Pixel value is 16*line+col; expected windows are queued as lines are sent
// and compared as the buffer hands them over.
// -----------------------------------------------------------------------------
module tb_line_window_buffer;

  localparam int NCOL = 4;
  localparam int NROW = 4;
  localparam int NWIN = 3;
  localparam int PD   = 24;

  typedef struct {
    logic [NWIN*PD-1:0] win;
    logic [1:0]         col;
  } exp_t;

  logic clk;
  logic rst;
  logic flush;
  exp_t sb[$];
  int   total_checks;
  int   bad_checks;

  line_window_buffer_if #(
    .P_COLUMNS(NCOL), .P_ROWS(NROW), .P_WINDOW(NWIN), .P_PIXEL_DEPTH(PD)
  ) bus ();

  line_window_buffer #(
    .P_COLUMNS(NCOL), .P_ROWS(NROW), .P_WINDOW(NWIN), .P_PIXEL_DEPTH(PD)
  ) dut (
    .I_CLK   (clk),
    .I_RESET (rst),
    .I_FLUSH (flush),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PD-1:0] pix(input int l, input int c);
    return PD'(16 * l + c);
  endfunction

  task automatic pushWindows(input int oldest);
    exp_t e;
    for (int c = 0; c < NCOL; c++) begin
      e.win = {pix(oldest + 2, c), pix(oldest + 1, c), pix(oldest, c)};
      e.col = 2'(c);
      sb.push_back(e);
    end
  endtask

  // Presents one pixel and returns 1 time unit after the edge that took it.
  task automatic pushPixel(input logic [PD-1:0] p);
    bus.I_PIXEL       = p;
    bus.I_PIXEL_VALID = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.O_PIXEL_READY) begin
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("pixTimeout", 128'(bus.O_PIXEL_READY), 128'(1));
  endtask

  task automatic applyStimulus(input int first, input int last);
    for (int l = first; l <= last; l++) begin
      for (int c = 0; c < NCOL; c++) begin
        pushPixel(pix(l, c));
      end
      if (l >= 2) pushWindows(l - 2);
    end
    bus.I_PIXEL_VALID = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    for (int t = 0; t < 100; t++) begin
      if (sb.size() == 0 && !bus.O_WINDOW_VALID) break;
      @(negedge clk);
    end
    checkOutput(tag, 128'(sb.size()), 128'(0));
  endtask

  task automatic doFlush(input string tag);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush             = 1'b0;
    bus.I_PIXEL_VALID = 1'b0;
    sb.delete();
    checkOutput({tag, "Rows"}, 128'(bus.O_ROWS_STORED), 128'(0));
    checkOutput({tag, "Valid"}, 128'(bus.O_WINDOW_VALID), 128'(0));
  endtask

  // Scoreboard consumer: every handed-over window must be the next expected.
  always @(negedge clk) begin
    if (!rst && bus.O_WINDOW_VALID && bus.I_WINDOW_READY) begin
      if (sb.size() == 0) begin
        checkOutput("sbUnderflow", 128'(sb.size()), 128'(1));
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("winData", 128'(bus.O_WINDOW), 128'(e.win));
        checkOutput("winCol", 128'(bus.O_WINDOW_COL), 128'(e.col));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    total_checks       = 0;
    bad_checks         = 0;
    rst                = 1'b1;
    flush              = 1'b0;
    bus.I_PIXEL        = '0;
    bus.I_PIXEL_VALID  = 1'b0;
    bus.I_WINDOW_READY = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstValid", 128'(bus.O_WINDOW_VALID), 128'(0));
    checkOutput("rstRows", 128'(bus.O_ROWS_STORED), 128'(0));
    checkOutput("rstCol", 128'(bus.O_WINDOW_COL), 128'(0));
    checkOutput("rstWin", 128'(bus.O_WINDOW), 128'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rstPixReady", 128'(bus.O_PIXEL_READY), 128'(1));

    // Fill: first window one cycle after the last pixel of line 2
    applyStimulus(0, 2);
    checkOutput("latPre", 128'(bus.O_WINDOW_VALID), 128'(0));
    @(posedge clk);
    #1;
    checkOutput("latValid", 128'(bus.O_WINDOW_VALID), 128'(1));
    checkOutput("latCol", 128'(bus.O_WINDOW_COL), 128'(0));
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("fillCol3", 128'(bus.O_WINDOW_COL), 128'(3));
    checkOutput("fillRows", 128'(bus.O_ROWS_STORED), 128'(2));
    waitDrain("fillDrain");
    doFlush("flushA");

    // Full stall: consumer blocked, ring fills, window holds
    bus.I_WINDOW_READY = 1'b0;
    applyStimulus(0, 3);
    checkOutput("fullPixReady", 128'(bus.O_PIXEL_READY), 128'(0));
    checkOutput("fullRows", 128'(bus.O_ROWS_STORED), 128'(4));
    checkOutput("holdWin", 128'(bus.O_WINDOW), 128'(72'h000020_000010_000000));
    checkOutput("holdCol", 128'(bus.O_WINDOW_COL), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    checkOutput("holdWin2", 128'(bus.O_WINDOW), 128'(72'h000020_000010_000000));
    bus.I_WINDOW_READY = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("stallPixReady", 128'(bus.O_PIXEL_READY), 128'(0));
    @(posedge clk);
    #1;
    checkOutput("releaseCol", 128'(bus.O_WINDOW_COL), 128'(3));
    checkOutput("releasePixReady", 128'(bus.O_PIXEL_READY), 128'(1));
    waitDrain("stallDrain");
    doFlush("flushB");

    // Simultaneous row complete and row retire
    applyStimulus(0, 3);
    checkOutput("simRows", 128'(bus.O_ROWS_STORED), 128'(3));
    checkOutput("simCol", 128'(bus.O_WINDOW_COL), 128'(3));
    @(posedge clk);
    #1;
    checkOutput("simNoGapValid", 128'(bus.O_WINDOW_VALID), 128'(1));
    checkOutput("simNoGapWin", 128'(bus.O_WINDOW), 128'(72'h000030_000020_000010));
    waitDrain("simDrain");
    doFlush("flushC");

    // Wrap: eight lines recycle the ring rows
    applyStimulus(0, 7);
    waitDrain("wrapDrain");
    doFlush("flushD");

    // Backpressure: consumer ready toggles every cycle
    fork
      applyStimulus(0, 2);
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge clk);
          #1;
          bus.I_WINDOW_READY = ~bus.I_WINDOW_READY;
        end
      end
    join
    bus.I_WINDOW_READY = 1'b1;
    waitDrain("bpDrain");
    doFlush("flushE");

    // Asynchronous reset in the middle of line 1
    applyStimulus(0, 0);
    pushPixel(pix(1, 0));
    pushPixel(pix(1, 1));
    bus.I_PIXEL_VALID = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midRstRows", 128'(bus.O_ROWS_STORED), 128'(0));
    checkOutput("midRstValid", 128'(bus.O_WINDOW_VALID), 128'(0));
    checkOutput("midRstWin", 128'(bus.O_WINDOW), 128'(0));
    checkOutput("midRstCol", 128'(bus.O_WINDOW_COL), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();

    // Flush mid-line with a held window and a pixel that must be dropped
    bus.I_WINDOW_READY = 1'b0;
    applyStimulus(0, 2);
    pushPixel(pix(3, 0));
    pushPixel(pix(3, 1));
    bus.I_PIXEL       = 24'h000055;
    bus.I_PIXEL_VALID = 1'b1;
    flush             = 1'b1;
    @(posedge clk);
    #1;
    flush             = 1'b0;
    bus.I_PIXEL_VALID = 1'b0;
    sb.delete();
    checkOutput("flushRows", 128'(bus.O_ROWS_STORED), 128'(0));
    checkOutput("flushValid", 128'(bus.O_WINDOW_VALID), 128'(0));
    checkOutput("flushPixReady", 128'(bus.O_PIXEL_READY), 128'(1));

    // Fill again after flush
    bus.I_WINDOW_READY = 1'b1;
    applyStimulus(0, 2);
    @(posedge clk);
    #1;
    checkOutput("refillValid", 128'(bus.O_WINDOW_VALID), 128'(1));
    waitDrain("refillDrain");

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
